// File: rtl/id_stage_hazard_pipe_pkg.sv
// Shared encoding constants, ID/EX control bundle and condition evaluation
// for the ARM decode stage.
package id_stage_hazard_pipe_pkg;

    localparam int WORD_WIDTH_DEF = 32;

    // Instruction mode field instr[27:26]
    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    // Data-processing opcode field instr[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU command codes seen by EX
    localparam logic [3:0] EX_NOP = 4'b0000;
    localparam logic [3:0] EX_MOV = 4'b0001;
    localparam logic [3:0] EX_ADD = 4'b0010;
    localparam logic [3:0] EX_ADC = 4'b0011;
    localparam logic [3:0] EX_SUB = 4'b0100;
    localparam logic [3:0] EX_SBC = 4'b0101;
    localparam logic [3:0] EX_AND = 4'b0110;
    localparam logic [3:0] EX_ORR = 4'b0111;
    localparam logic [3:0] EX_EOR = 4'b1000;
    localparam logic [3:0] EX_MVN = 4'b1001;

    // Condition codes instr[31:28]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Control half of the ID/EX register
    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic       b;
        logic       s;
        logic       imm;
        logic [3:0] ex_cmd;
    } idex_ctrl_t;

    // Evaluate an ARM condition code against N,Z,C,V; 0xF never executes
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_hazard_pipe_regfile_bypass.sv
// 16-entry register file, two combinational read ports, one write port,
// with optional same-cycle write-through to the read ports.
module id_stage_hazard_pipe_regfile_bypass
    import id_stage_hazard_pipe_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [3:0]            wb_addr,
    input  logic [WORD_WIDTH-1:0] wb_data,
    input  logic [3:0]            rd_addr1,
    input  logic [3:0]            rd_addr2,
    output logic [WORD_WIDTH-1:0] rd_data1,
    output logic [WORD_WIDTH-1:0] rd_data2
);

    logic [WORD_WIDTH-1:0] regs_q [16];
    logic [WORD_WIDTH-1:0] regs_d [16];

    // Next register contents: copy, then apply the writeback
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports; a same-cycle write to the read address wins when bypass is on
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
        if (BYPASS_EN && wb_en && (wb_addr == rd_addr1)) begin
            rd_data1 = wb_data;
        end
        if (BYPASS_EN && wb_en && (wb_addr == rd_addr2)) begin
            rd_data2 = wb_data;
        end
    end

endmodule

// File: rtl/id_stage_hazard_pipe.sv
// ARM decode stage: decode, register read, condition check, RAW hazard
// detection and the ID/EX pipeline register with freeze/flush/bubble.
module id_stage_hazard_pipe
    import id_stage_hazard_pipe_pkg::*;
#(
    parameter int WORD_WIDTH    = WORD_WIDTH_DEF,
    parameter bit FORWARDING_EN = 1'b1,
    parameter bit BYPASS_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze_in,
    input  logic                  flush,
    input  logic                  instr_valid,
    input  logic [31:0]           instruction_in,
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic [3:0]            status_reg,
    input  logic                  wb_en,
    input  logic [3:0]            wb_addr,
    input  logic [WORD_WIDTH-1:0] wb_data,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_read,
    input  logic [3:0]            ex_dst,
    input  logic                  mem_wb_en,
    input  logic [3:0]            mem_dst,
    output logic                  hazard_stall,
    output logic                  idex_valid,
    output logic                  idex_wb_en,
    output logic                  idex_mem_read,
    output logic                  idex_mem_write,
    output logic                  idex_b,
    output logic                  idex_s,
    output logic                  idex_imm,
    output logic [3:0]            idex_ex_cmd,
    output logic [3:0]            idex_dst,
    output logic [3:0]            idex_src1,
    output logic [3:0]            idex_src2,
    output logic [WORD_WIDTH-1:0] idex_pc,
    output logic [WORD_WIDTH-1:0] idex_val_rn,
    output logic [WORD_WIDTH-1:0] idex_val_rm,
    output logic [11:0]           idex_shift_op,
    output logic [23:0]           idex_simm
);

    logic [1:0] mode;
    logic [3:0] opcode;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dst;
    logic       uses_src1;
    logic       uses_src2;
    logic       cond_ok;
    logic       raw_fwd;
    logic       raw_nofwd;
    idex_ctrl_t dec_ctrl;

    logic [WORD_WIDTH-1:0] rd_data1;
    logic [WORD_WIDTH-1:0] rd_data2;

    idex_ctrl_t            ctrl_q,  ctrl_d;
    logic [3:0]            dst_q,   dst_d;
    logic [3:0]            src1_q,  src1_d;
    logic [3:0]            src2_q,  src2_d;
    logic [WORD_WIDTH-1:0] pc_q,    pc_d;
    logic [WORD_WIDTH-1:0] rn_q,    rn_d;
    logic [WORD_WIDTH-1:0] rm_q,    rm_d;
    logic [11:0]           shift_q, shift_d;
    logic [23:0]           simm_q,  simm_d;

    assign mode   = instruction_in[27:26];
    assign opcode = instruction_in[24:21];
    assign src1   = instruction_in[19:16];
    assign dst    = instruction_in[15:12];

    // Instruction decode into the ID/EX control bundle
    always_comb begin
        dec_ctrl        = '0;
        dec_ctrl.valid  = 1'b1;
        dec_ctrl.imm    = instruction_in[25];
        dec_ctrl.s      = instruction_in[20];
        dec_ctrl.ex_cmd = EX_NOP;
        uses_src1       = 1'b0;
        case (mode)
            MODE_ARITH: begin
                uses_src1      = 1'b1;
                dec_ctrl.wb_en = 1'b1;
                case (opcode)
                    OP_MOV: begin dec_ctrl.ex_cmd = EX_MOV; uses_src1 = 1'b0; end
                    OP_MVN: begin dec_ctrl.ex_cmd = EX_MVN; uses_src1 = 1'b0; end
                    OP_ADD: dec_ctrl.ex_cmd = EX_ADD;
                    OP_ADC: dec_ctrl.ex_cmd = EX_ADC;
                    OP_SUB: dec_ctrl.ex_cmd = EX_SUB;
                    OP_SBC: dec_ctrl.ex_cmd = EX_SBC;
                    OP_AND: dec_ctrl.ex_cmd = EX_AND;
                    OP_ORR: dec_ctrl.ex_cmd = EX_ORR;
                    OP_EOR: dec_ctrl.ex_cmd = EX_EOR;
                    OP_CMP: begin dec_ctrl.ex_cmd = EX_SUB; dec_ctrl.wb_en = 1'b0; end
                    OP_TST: begin dec_ctrl.ex_cmd = EX_AND; dec_ctrl.wb_en = 1'b0; end
                    default: begin dec_ctrl.wb_en = 1'b0; uses_src1 = 1'b0; end
                endcase
            end
            MODE_MEM: begin
                dec_ctrl.ex_cmd = EX_ADD;
                uses_src1       = 1'b1;
                if (instruction_in[20]) begin
                    dec_ctrl.mem_read = 1'b1;
                    dec_ctrl.wb_en    = 1'b1;
                end else begin
                    dec_ctrl.mem_write = 1'b1;
                end
            end
            MODE_BRANCH: dec_ctrl.b = 1'b1;
            default: ;
        endcase
        // Stores read their data register from the Rd field
        src2      = dec_ctrl.mem_write ? instruction_in[15:12] : instruction_in[3:0];
        uses_src2 = ~dec_ctrl.imm | dec_ctrl.mem_write;
    end

    assign cond_ok = cond_pass(instruction_in[31:28], status_reg);

    id_stage_hazard_pipe_regfile_bypass #(
        .WORD_WIDTH (WORD_WIDTH),
        .BYPASS_EN  (BYPASS_EN)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_addr1 (src1),
        .rd_addr2 (src2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    // RAW hazard: load-use only with forwarding, any EX/MEM match without
    always_comb begin
        raw_fwd   = ex_mem_read & ((uses_src1 & (src1 == ex_dst)) |
                                   (uses_src2 & (src2 == ex_dst)));
        raw_nofwd = (uses_src1 & ((ex_wb_en & (src1 == ex_dst)) | (mem_wb_en & (src1 == mem_dst)))) |
                    (uses_src2 & ((ex_wb_en & (src2 == ex_dst)) | (mem_wb_en & (src2 == mem_dst))));
        hazard_stall = instr_valid & ~flush & (FORWARDING_EN ? raw_fwd : raw_nofwd);
    end

    // ID/EX next state: freeze holds, otherwise load decode and squash control on a bubble
    always_comb begin
        ctrl_d  = ctrl_q;
        dst_d   = dst_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        pc_d    = pc_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        shift_d = shift_q;
        simm_d  = simm_q;
        if (!freeze_in) begin
            ctrl_d  = dec_ctrl;
            dst_d   = dst;
            src1_d  = src1;
            src2_d  = src2;
            pc_d    = pc_in;
            rn_d    = rd_data1;
            rm_d    = rd_data2;
            shift_d = instruction_in[11:0];
            simm_d  = instruction_in[23:0];
            if (flush || hazard_stall || !instr_valid || !cond_ok) begin
                ctrl_d.valid     = 1'b0;
                ctrl_d.wb_en     = 1'b0;
                ctrl_d.mem_read  = 1'b0;
                ctrl_d.mem_write = 1'b0;
                ctrl_d.b         = 1'b0;
                ctrl_d.s         = 1'b0;
            end
        end
    end

    // ID/EX pipeline register, fully cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            dst_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            pc_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= '0;
            simm_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            dst_q   <= dst_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            pc_q    <= pc_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            shift_q <= shift_d;
            simm_q  <= simm_d;
        end
    end

    assign idex_valid     = ctrl_q.valid;
    assign idex_wb_en     = ctrl_q.wb_en;
    assign idex_mem_read  = ctrl_q.mem_read;
    assign idex_mem_write = ctrl_q.mem_write;
    assign idex_b         = ctrl_q.b;
    assign idex_s         = ctrl_q.s;
    assign idex_imm       = ctrl_q.imm;
    assign idex_ex_cmd    = ctrl_q.ex_cmd;
    assign idex_dst       = dst_q;
    assign idex_src1      = src1_q;
    assign idex_src2      = src2_q;
    assign idex_pc        = pc_q;
    assign idex_val_rn    = rn_q;
    assign idex_val_rm    = rm_q;
    assign idex_shift_op  = shift_q;
    assign idex_simm      = simm_q;

endmodule
